// File: rtl/dmem_pipe.sv
// ---------------------------------------------------------------------------
// dmem_pipe -- data memory for the MEM stage of the pipelined CPU.
//
// Word / halfword / byte loads and stores with sign or zero extension behind
// a valid/ready request port. Responses come back in order, exactly RD_LAT
// cycles after acceptance (visible after edge n+RD_LAT for a request
// accepted at edge n). Misaligned, out-of-range and illegal-size accesses are
// flagged on rsp_err and leave the array untouched. After reset the array is
// zeroed by a hardware sweep, one word per cycle, while busy is high.
//
// Parameters:
//   ADDR_W    word-address bits, depth = 2**ADDR_W words (1..29)
//   RD_LAT    request-to-response latency in cycles (1..4)
//   BASE_ADDR byte address mapped to word 0
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   req_valid    request present
//   req_ready    request accepted when req_valid && req_ready
//   req_we       1 = store, 0 = load
//   req_size     00 word, 01 half, 10 byte, 11 illegal
//   req_unsigned zero-extend loads
//   req_addr     byte address
//   req_wdata    store data (low bits for half/byte)
//   req_pc       instruction PC, used by the store trace only
//   rsp_valid    one response per accepted request
//   rsp_rdata    extended load data, 0 for stores / errors / idle
//   rsp_err      access was misaligned, out of range or illegal
//   busy         clear sweep in progress
//
// Build option:
//   DMEM_PIPE_TRACE_EN  when defined, every accepted error-free store prints
//                       "<time>@<pc>: *<word byte addr> <= <merged word>".
// ---------------------------------------------------------------------------
module dmem_pipe #(
   parameter int          ADDR_W    = 12,
   parameter int          RD_LAT    = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;

   logic [31:0] mem [DEPTH];

   // ------------------------------------------------------------------
   // Request decode: offset, word index, error detection
   // ------------------------------------------------------------------
   logic [31:0]       off;
   logic [ADDR_W-1:0] widx;
   logic              err;
   logic              accept;

   assign accept = req_valid && req_ready;

   // NOTE: every always_comb output gets a default on entry so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      off  = req_addr - BASE_ADDR;
      widx = off[ADDR_W+1:2];
      err  = 1'b0;
      unique case (req_size)
         SZ_WORD: err = (off[1:0] != 2'b00);
         SZ_HALF: err = off[0];
         SZ_BYTE: err = 1'b0;
         default: err = 1'b1;
      endcase
      // Any offset bit above the array span means out of range.
      if ((off >> (ADDR_W + 2)) != 32'd0) err = 1'b1;
   end

   // ------------------------------------------------------------------
   // Lane merge for stores and lane select / extension for loads.
   // Both work on the current contents of the addressed word, so a load
   // sees a store accepted on the previous edge.
   // ------------------------------------------------------------------
   logic [31:0] old_word;
   logic [31:0] merged_word;
   logic [31:0] load_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      old_word    = mem[widx];
      merged_word = old_word;
      byte_sel    = old_word[{off[1:0], 3'b000} +: 8];
      half_sel    = off[1] ? old_word[31:16] : old_word[15:0];
      load_data   = 32'd0;

      unique case (req_size)
         SZ_WORD: begin
            merged_word = req_wdata;
            load_data   = old_word;
         end
         SZ_HALF: begin
            if (off[1]) merged_word[31:16] = req_wdata[15:0];
            else        merged_word[15:0]  = req_wdata[15:0];
            load_data = req_unsigned ? {16'd0, half_sel}
                                     : {{16{half_sel[15]}}, half_sel};
         end
         SZ_BYTE: begin
            merged_word[{off[1:0], 3'b000} +: 8] = req_wdata[7:0];
            load_data = req_unsigned ? {24'd0, byte_sel}
                                     : {{24{byte_sel[7]}}, byte_sel};
         end
         default: begin
            merged_word = old_word;
            load_data   = 32'd0;
         end
      endcase

      // Stores and faulting accesses return zero data.
      if (req_we || err) load_data = 32'd0;
   end

   // ------------------------------------------------------------------
   // Control FSM: CLEAR sweep after reset, then RUN.
   // req_ready / busy are registered so they change only on clock edges.
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_CLEAR;
         clr_cnt   <= '0;
         req_ready <= 1'b0;
         busy      <= 1'b1;
      end else begin
         unique case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (&clr_cnt) begin
                  state     <= ST_RUN;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            ST_RUN: begin
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= ST_CLEAR;
               clr_cnt   <= '0;
               req_ready <= 1'b0;
               busy      <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Array write port: sweep writes during CLEAR, stores during RUN.
   // Nothing is written on an edge where reset is asserted.
   // ------------------------------------------------------------------
   // NOTE: the array itself has no reset branch; it is zeroed by the sweep
   // so it can still map onto a RAM macro.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == ST_CLEAR) begin
            mem[clr_cnt] <= 32'd0;
         end else if (accept && req_we && !err) begin
            mem[widx] <= merged_word;
         end
      end
   end

   // ------------------------------------------------------------------
   // Response pipeline: (valid, err, rdata) captured at acceptance and
   // shifted RD_LAT stages, followed by the output register.
   // ------------------------------------------------------------------
   logic [RD_LAT-1:0] pipe_valid;
   logic [RD_LAT-1:0] pipe_err;
   logic [31:0]       pipe_data [RD_LAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= 32'd0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= 32'd0;
      end else begin
         pipe_valid[0] <= accept;
         pipe_err[0]   <= accept && err;
         pipe_data[0]  <= accept ? load_data : 32'd0;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_err[i]   <= pipe_err[i-1];
            pipe_data[i]  <= pipe_data[i-1];
         end
         rsp_valid <= pipe_valid[RD_LAT-1];
         rsp_err   <= pipe_valid[RD_LAT-1] && pipe_err[RD_LAT-1];
         rsp_rdata <= pipe_valid[RD_LAT-1] ? pipe_data[RD_LAT-1] : 32'd0;
      end
   end

   // ------------------------------------------------------------------
   // Optional store trace
   // ------------------------------------------------------------------
`ifdef DMEM_PIPE_TRACE_EN
   logic [31:0] trace_addr;
   assign trace_addr = BASE_ADDR + (32'(widx) << 2);

   always_ff @(posedge clk) begin
      if (!reset && accept && req_we && !err) begin
         $display("%d@%h: *%h <= %h", $time, req_pc, trace_addr, merged_word);
      end
   end
`else
   // req_pc only feeds the trace; fold it away when the trace is off.
   logic unused_req_pc;
   assign unused_req_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dmem_pipe.sv
// ---------------------------------------------------------------------------
// tb_dmem_pipe -- scoreboard bench for dmem_pipe.
//
// Two instances (RD_LAT=1 and RD_LAT=3, ADDR_W=4) share one request stream.
// The driver computes each expected response from a byte-array model of the
// memory and pushes it, with its due cycle, into a per-instance queue; a
// monitor on the falling edge pops and compares whenever rsp_valid is high.
// ---------------------------------------------------------------------------
module tb_dmem_pipe;

   localparam int          ADDR_W    = 4;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
   localparam int          NBYTES    = 4 << ADDR_W;
   localparam int          WORDS     = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;

   logic        ready1, ready3;
   logic        busy1, busy3;
   logic        vld1, vld3;
   logic        err1, err3;
   logic [31:0] rd1, rd3;

   always #5 clk = ~clk;

   dmem_pipe #(.ADDR_W(ADDR_W), .RD_LAT(1), .BASE_ADDR(BASE_ADDR)) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_pc(req_pc),
      .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(err1), .busy(busy1)
   );

   dmem_pipe #(.ADDR_W(ADDR_W), .RD_LAT(3), .BASE_ADDR(BASE_ADDR)) u_dut3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(ready3), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_pc(req_pc),
      .rsp_valid(vld3), .rsp_rdata(rd3), .rsp_err(err3), .busy(busy3)
   );

   // ------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------
   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic [7:0] mem_m [NBYTES];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: little-endian byte array, rules applied directly.
   // ------------------------------------------------------------------
   function automatic void model(input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err);
      logic [31:0] off;
      int          nb;
      off   = addr - BASE_ADDR;
      nb    = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
      err   = (size == 2'b11) || (off >= 32'(NBYTES)) || ((off % 32'(nb)) != 0);
      rdata = 32'd0;
      if (err) return;
      if (we) begin
         for (int i = 0; i < nb; i++) mem_m[int'(off) + i] = wdata[8*i +: 8];
      end else begin
         for (int i = 0; i < nb; i++) rdata |= 32'(mem_m[int'(off) + i]) << (8 * i);
         if (nb < 4 && !uns && rdata[8*nb-1]) rdata |= 32'hFFFF_FFFF << (8 * nb);
      end
   endfunction

   // ------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------
   task automatic mon_step(input int lat, input logic v, input logic e, input logic [31:0] d);
      exp_t x;
      bit   have;
      have = (lat == 1) ? (q1.size() > 0) : (q3.size() > 0);
      if (have) x = (lat == 1) ? q1[0] : q3[0];
      if (v) begin
         if (!have) begin
            check($sformatf("L%0d unexpected rsp_valid", lat), 32'(v), 32'd0);
         end else begin
            if (lat == 1) void'(q1.pop_front());
            else          void'(q3.pop_front());
            check($sformatf("L%0d rsp cycle", lat), cyc, x.due);
            check($sformatf("L%0d rsp_rdata", lat), d, x.data);
            check($sformatf("L%0d rsp_err", lat), 32'(e), 32'(x.err));
         end
      end else begin
         check($sformatf("L%0d idle rdata", lat), d, 32'd0);
         check($sformatf("L%0d idle err", lat), 32'(e), 32'd0);
         if (have && x.due <= cyc) begin
            check($sformatf("L%0d missing rsp_valid", lat), 32'(v), 32'd1);
            if (lat == 1) void'(q1.pop_front());
            else          void'(q3.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         mon_step(1, vld1, err1, rd1);
         mon_step(3, vld3, err3, rd3);
      end
   end

   // ------------------------------------------------------------------
   // Driver tasks (called right after a falling edge)
   // ------------------------------------------------------------------
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      exp_t x;
      logic [31:0] rdata;
      logic        err;
      check("req_ready at issue", {30'd0, ready3, ready1}, 32'd3);
      model(we, size, uns, addr, wdata, rdata, err);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_pc       = 32'h0000_1000 + 32'(cyc << 2);
      x.data = rdata;
      x.err  = err;
      x.due  = cyc + 1 + 1;
      q1.push_back(x);
      x.due  = cyc + 1 + 3;
      q3.push_back(x);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic reset_and_sweep();
      reset     = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      q1.delete();
      q3.delete();
      for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
      @(negedge clk);
      check("reset req_ready", {30'd0, ready3, ready1}, 32'd0);
      check("reset busy", {30'd0, busy3, busy1}, 32'd3);
      check("reset rsp_valid", {30'd0, vld3, vld1}, 32'd0);
      check("reset rsp_rdata1", rd1, 32'd0);
      check("reset rsp_rdata3", rd3, 32'd0);
      check("reset rsp_err", {30'd0, err3, err1}, 32'd0);
      reset = 1'b0;
      for (int k = 1; k <= WORDS; k++) begin
         @(negedge clk);
         check($sformatf("sweep ready k=%0d", k), {30'd0, ready3, ready1},
               (k == WORDS) ? 32'd3 : 32'd0);
         check($sformatf("sweep busy k=%0d", k), {30'd0, busy3, busy1},
               (k == WORDS) ? 32'd0 : 32'd3);
      end
   endtask

   task automatic random_ops(input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 15));
         issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      req_pc       = 32'd0;

      reset_and_sweep();

      // Fresh array reads zero.
      issue(1'b0, 2'b00, 1'b0, 32'h8, 32'd0);
      idle(2);

      // Byte merge into a word, signed / unsigned byte loads.
      issue(1'b1, 2'b00, 1'b0, 32'h8, 32'h1234_5678);
      issue(1'b1, 2'b10, 1'b0, 32'h9, 32'h0000_00AB);
      issue(1'b0, 2'b10, 1'b0, 32'h9, 32'd0);
      issue(1'b0, 2'b10, 1'b1, 32'h9, 32'd0);
      issue(1'b0, 2'b00, 1'b0, 32'h8, 32'd0);
      idle(4);

      // Halfword store to the upper lane.
      issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_8001);
      issue(1'b0, 2'b01, 1'b0, 32'h6, 32'd0);
      issue(1'b0, 2'b01, 1'b1, 32'h6, 32'd0);
      issue(1'b0, 2'b00, 1'b0, 32'h4, 32'd0);
      idle(4);

      // Faulting accesses leave word 0 intact.
      issue(1'b1, 2'b00, 1'b0, 32'h0, 32'hCAFE_F00D);
      issue(1'b1, 2'b00, 1'b0, 32'h2, 32'h1111_1111);
      issue(1'b0, 2'b00, 1'b0, 32'h0, 32'd0);
      issue(1'b0, 2'b01, 1'b0, 32'h1, 32'd0);
      issue(1'b0, 2'b00, 1'b0, 32'h0, 32'd0);
      issue(1'b1, 2'b11, 1'b0, 32'h0, 32'h2222_2222);
      issue(1'b0, 2'b00, 1'b0, 32'h0, 32'd0);
      issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h3333_3333);
      issue(1'b0, 2'b00, 1'b0, 32'h40, 32'd0);
      issue(1'b0, 2'b00, 1'b0, 32'h0, 32'd0);
      idle(4);

      // Store immediately followed by a load of the same word.
      issue(1'b1, 2'b00, 1'b0, 32'hC, 32'hDEAD_BEEF);
      issue(1'b0, 2'b00, 1'b0, 32'hC, 32'd0);
      idle(5);

      random_ops(300);
      idle(5);

      // Reset with two loads in flight in the RD_LAT=3 instance.
      issue(1'b0, 2'b00, 1'b0, 32'hC, 32'd0);
      issue(1'b0, 2'b00, 1'b0, 32'h8, 32'd0);
      reset_and_sweep();
      issue(1'b1, 2'b10, 1'b0, 32'h9, 32'h0000_005A);
      issue(1'b0, 2'b00, 1'b0, 32'h8, 32'd0);
      issue(1'b0, 2'b00, 1'b0, 32'hC, 32'd0);
      idle(3);

      random_ops(150);
      idle(8);

      check("q1 drained", 32'(q1.size()), 32'd0);
      check("q3 drained", 32'(q3.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound.
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_pipe.md
# dmem_pipe

Parametrised data-memory block for the pipelined CPU's MEM stage. Supports word, halfword and byte loads/stores with sign or zero extension and a valid/ready request port. Read latency is configurable, and misaligned or out-of-range accesses are detected. After reset, the block clears its array with a hardware sweep rather than an initial loop.

## Interface
Parameters:
- `ADDR_W`, default 12: word-address bits; depth = 2^ADDR_W words.
- `RD_LAT`, default 1: request-to-response latency in cycles; legal range 1..4.
- `BASE_ADDR`, default 32'h0000_0000: byte address mapped to word 0.

Ports (reset: synchronous, active-high; clock: `clk`):
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request; a request is accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 word, 01 half, 10 byte, 11 illegal.
- `req_unsigned` in 1: zero-extend loads (lhu/lbu).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; low bits used for half/byte.
- `req_pc` in 32: instruction PC, used only for the trace.
- `rsp_valid` out 1: response present, one cycle per accepted request.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: the access was misaligned, out of range or illegal.
- `busy` out 1: clear sweep in progress.

## Operation
- States:
  - CLEAR: entered on reset. A counter walks words 0..2^ADDR_W-1 writing 0, one word per cycle. `req_ready`=0, `busy`=1. After writing the last word, go to RUN.
  - RUN: `req_ready`=1, `busy`=0.
- Offset: off = req_addr - BASE_ADDR (32-bit unsigned). Word index = off[ADDR_W+1:2].
- Error conditions; any one sets err:
  - size 11;
  - word with off[1:0]≠0;
  - half with off[0]≠0;
  - off[31:ADDR_W+2]≠0 (out of range).
- Store without error: write only the addressed lanes; the other lanes keep their old value.
  - Byte lane k = off[1:0] receives wdata[7:0].
  - Half lane off[1] receives wdata[15:0].
  - Word writes all 32 bits.
- Store with error: the array is unchanged.
- Load without error:
  - Select the lane by off[1:0] / off[1].
  - Sign-extend from bit 7/15 unless `req_unsigned`, in which case zero-extend.
  - A word load returns the word as stored.
- Load with error: rdata = 0.
- Every accepted request produces exactly one response after RD_LAT cycles, in order. There is no response backpressure; the consumer must take every response.
- The read data and err flag are computed at acceptance and carried through an RD_LAT-deep shift pipeline of (valid, err, rdata).

## Timing
- Reset values:
  - `req_ready`=0, `busy`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - Pipeline valid bits cleared; clear counter = 0.
- Clear sweep length: `req_ready` rises exactly 2^ADDR_W cycles after the first clock edge with `reset` low.
- Throughput: one request per cycle in RUN.
- Latency: a request accepted at edge n has its response visible after edge n+RD_LAT.
- The array write takes effect at the accepting edge. A load accepted at edge n+1 sees a store accepted at edge n.
- `reset` asserted mid-operation:
  - In-flight responses are dropped (`rsp_valid`=0 next cycle).
  - Pending lanes are not written.
  - The block re-enters CLEAR with the counter at 0.
- `req_valid` while in CLEAR: not accepted, no response; the requester must hold its request.
- Outputs: `rsp_rdata` and `rsp_err` hold 0 whenever `rsp_valid`=0.

## Configuration
- `DMEM_PIPE_TRACE_EN` defined:
  - Each accepted, error-free store prints `$display("%d@%h: *%h <= %h", $time, req_pc, {word_byte_addr}, merged_word)` at the accepting edge.
  - `word_byte_addr` = BASE_ADDR + (word index << 2), i.e. the byte address of word 0 is added back.
  - `merged_word` is the full 32-bit word after lane merge.
  - Clear-sweep writes and errored stores print nothing.
- Not defined: no trace output; the functional behaviour is identical.

## Test plan
1. ADDR_W=4: assert `reset` 1 cycle, then release -> `busy`=1 and `req_ready`=0 for 16 cycles, then `req_ready`=1. A load from 0x8 returns 0.
2. Word store 0x8 <= 0x1234_5678, then byte store 0x9 <= 0xAB -> lb 0x9 gives 0xFFFF_FFAB; lbu 0x9 gives 0x0000_00AB; lw 0x8 gives 0x1234_AB78. Each response arrives exactly RD_LAT cycles after its request, checked for RD_LAT=1 and RD_LAT=3.
3. Half store 0x6 <= 0x0000_8001 -> lh 0x6 gives 0xFFFF_8001; lhu 0x6 gives 0x0000_8001; lw 0x4 gives 0x8001_0000.
4. Misaligned and illegal cases each give `rsp_err`=1, `rsp_rdata`=0, and a following lw 0x0 shows word 0 unchanged:
   - sw to 0x2;
   - lh from 0x1;
   - size 11;
   - address 0x40 with ADDR_W=4.
5. Back-to-back: sw 0xC <= 0xDEAD_BEEF, then lw 0xC on the next cycle -> the load returns 0xDEAD_BEEF. Store and load responses come out in order on consecutive cycles.
6. Assert `reset` while two loads are in flight (RD_LAT=3) -> no `rsp_valid` after reset and the clear sweep restarts. With `DMEM_PIPE_TRACE_EN` defined, a store to 0x9 prints address 0x00000008 and the merged word.
